// File: rtl/reg_seq_pkg.sv
// Shared opcode and FSM state definitions for the register-bank command sequencer.
package reg_seq_pkg;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_MOV  = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_A  = 2'd1,
    RD_B  = 2'd2,
    WRITE = 2'd3
  } state_t;

endpackage

// File: rtl/addr_onehot_dec.sv
// Address to one-hot decoder with enable; all zeros when disabled.
module addr_onehot_dec #(
  parameter int AW    = 2,
  parameter int NREGS = 4
) (
  input  logic [AW-1:0]    addr,
  input  logic             en,
  output logic [NREGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/reg_bank_sequencer.sv
// Sequences LOAD/MOV/ADD/CLR commands into a register bank through one shared read port
// and a one-hot registered write strobe.
module reg_bank_sequencer
  import reg_seq_pkg::*;
#(
  parameter int W     = 4,
  parameter int NREGS = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [AW-1:0]    cmd_rd,
  input  logic [AW-1:0]    cmd_rs,
  input  logic [AW-1:0]    cmd_rt,
  input  logic [W-1:0]     cmd_imm,
  output logic [AW-1:0]    rd_addr,
  input  logic [W-1:0]     rd_data,
  output logic [NREGS-1:0] wr_en,
  output logic [W-1:0]     wr_data,
  output logic             done,
  output logic             carry,
  output logic             busy
);

  state_t           state;
  logic [1:0]       op_q;
  logic [AW-1:0]    rd_q;
  logic [AW-1:0]    rt_q;
  logic [W-1:0]     op_a;

  logic             go_write;
  logic             clr_next;
  logic [AW-1:0]    wr_addr;
  logic [NREGS-1:0] dec_onehot;
  logic [W:0]       sum;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Write-cycle outputs are registered, so they are computed on the edge that enters WRITE;
  // operand B is therefore summed straight from the read port instead of a holding register.
  always_comb begin
    go_write = 1'b0;
    clr_next = 1'b0;
    wr_addr  = rd_q;
    sum      = {1'b0, op_a} + {1'b0, rd_data};
    case (state)
      IDLE: begin
        wr_addr  = cmd_rd;
        go_write = cmd_valid && (cmd_op == OP_LOAD || cmd_op == OP_CLR);
        clr_next = cmd_valid && (cmd_op == OP_CLR);
      end
      RD_A:    go_write = (op_q == OP_MOV);
      RD_B:    go_write = 1'b1;
      default: go_write = 1'b0;
    endcase
  end

  addr_onehot_dec #(
    .AW    (AW),
    .NREGS (NREGS)
  ) u_dec (
    .addr   (wr_addr),
    .en     (go_write),
    .onehot (dec_onehot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op_q    <= OP_LOAD;
      rd_q    <= '0;
      rt_q    <= '0;
      op_a    <= '0;
      rd_addr <= '0;
      wr_en   <= '0;
      wr_data <= '0;
      done    <= 1'b0;
      carry   <= 1'b0;
    end else begin
      wr_en <= clr_next ? '1 : dec_onehot;
      done  <= go_write;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q <= cmd_op;
            rd_q <= cmd_rd;
            rt_q <= cmd_rt;
            case (cmd_op)
              OP_LOAD: begin
                wr_data <= cmd_imm;
                state   <= WRITE;
              end
              OP_CLR: begin
                wr_data <= '0;
                carry   <= 1'b0;
                state   <= WRITE;
              end
              default: begin
                rd_addr <= cmd_rs;
                state   <= RD_A;
              end
            endcase
          end
        end
        RD_A: begin
          op_a <= rd_data;
          if (op_q == OP_MOV) begin
            wr_data <= rd_data;
            state   <= WRITE;
          end else begin
            rd_addr <= rt_q;
            state   <= RD_B;
          end
        end
        RD_B: begin
          {carry, wr_data} <= sum;
          state            <= WRITE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_sequencer.sv
// Randomised self-checking bench: a behavioural bank plus an architectural register model.
module tb_reg_bank_sequencer;

  localparam int W     = 4;
  localparam int NREGS = 4;
  localparam int AW    = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [AW-1:0]    cmd_rd, cmd_rs, cmd_rt;
  logic [W-1:0]     cmd_imm;
  logic [AW-1:0]    rd_addr;
  logic [W-1:0]     rd_data;
  logic [NREGS-1:0] wr_en;
  logic [W-1:0]     wr_data;
  logic             done, carry, busy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [W-1:0] bank [NREGS];
  int           ref_regs [NREGS];
  int           ref_carry;

  always #5 clk = ~clk;

  reg_bank_sequencer #(.W(W), .NREGS(NREGS), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rd    (cmd_rd),
    .cmd_rs    (cmd_rs),
    .cmd_rt    (cmd_rt),
    .cmd_imm   (cmd_imm),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .done      (done),
    .carry     (carry),
    .busy      (busy)
  );

  // Environment register bank: combinational read, write on the edge ending the write cycle.
  assign rd_data = bank[rd_addr];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) bank[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) if (wr_en[i]) bank[i] <= wr_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) ref_regs[i] = 0;
    ref_carry = 0;
  endtask

  // Issues one command and checks read addresses, write cycle contents, latency and handshake.
  task automatic run_cmd(input int op, input int rd, input int rs, input int rt, input int imm);
    int exp_lat, exp_en, exp_data, exp_carry, total;
    int ndone, seen, guard;
    case (op)
      0: begin exp_lat = 1; exp_data = imm; exp_en = 1 << rd; exp_carry = ref_carry; end
      1: begin exp_lat = 2; exp_data = ref_regs[rs]; exp_en = 1 << rd; exp_carry = ref_carry; end
      2: begin
        total     = ref_regs[rs] + ref_regs[rt];
        exp_lat   = 3;
        exp_data  = total % 16;
        exp_carry = total / 16;
        exp_en    = 1 << rd;
      end
      default: begin exp_lat = 1; exp_data = 0; exp_en = 15; exp_carry = 0; end
    endcase

    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_rd    = AW'(rd);
    cmd_rs    = AW'(rs);
    cmd_rt    = AW'(rt);
    cmd_imm   = W'(imm);
    guard     = 0;
    while (!cmd_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_accept", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    ndone = 0;
    seen  = 0;
    for (int k = 1; k <= 6; k++) begin
      if ((op == 1 || op == 2) && k == 1) check("rd_addr_rs", 32'(rd_addr), 32'(rs));
      if (op == 2 && k == 2)              check("rd_addr_rt", 32'(rd_addr), 32'(rt));
      if (k <= exp_lat + 1) check("busy", 32'(busy), 32'(k <= exp_lat));
      if (k == exp_lat + 1) check("ready_after_write", 32'(cmd_ready), 32'd1);
      if (done) begin
        ndone++;
        seen = k;
        check("wr_en", 32'(wr_en), 32'(exp_en));
        check("wr_data", 32'(wr_data), 32'(exp_data));
        check("carry", 32'(carry), 32'(exp_carry));
      end else begin
        check("wr_en_idle", 32'(wr_en), 32'd0);
      end
      @(negedge clk);
    end
    check("done_count", 32'(ndone), 32'd1);
    check("latency", 32'(seen), 32'(exp_lat));

    if (op == 3) begin
      for (int i = 0; i < NREGS; i++) ref_regs[i] = 0;
    end else begin
      ref_regs[rd] = exp_data;
    end
    ref_carry = exp_carry;
  endtask

  task automatic check_bank();
    for (int i = 0; i < NREGS; i++) check("bank", 32'(bank[i]), 32'(ref_regs[i]));
  endtask

  initial begin
    int ndone;
    int first_done, second_done;
    cmd_valid = 1'b0;
    cmd_op = '0; cmd_rd = '0; cmd_rs = '0; cmd_rt = '0; cmd_imm = '0;
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_carry", 32'(carry), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    rst = 1'b0;

    // Directed: load, add with carry, aliasing mov/add, clear after carry.
    run_cmd(0, 2, 0, 0, 'hA);
    run_cmd(0, 1, 0, 0, 5);
    run_cmd(0, 3, 0, 0, 'hC);
    run_cmd(2, 0, 1, 3, 0);
    check("add_carry_kept", 32'(carry), 32'd1);
    run_cmd(0, 2, 0, 0, 7);
    run_cmd(1, 2, 2, 0, 0);
    run_cmd(2, 2, 2, 2, 0);
    run_cmd(0, 1, 0, 0, 'hF);
    run_cmd(2, 0, 1, 1, 0);
    run_cmd(3, 0, 0, 0, 0);
    check_bank();

    // Held valid while busy: second command waits until the cycle after the first write.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_rd = 2'd1; cmd_imm = 4'h3;
    @(negedge clk);
    cmd_op = 2'd1; cmd_rd = 2'd0; cmd_rs = 2'd1;
    ndone = 0; first_done = 0; second_done = 0;
    for (int k = 1; k <= 7; k++) begin
      if (k == 1) check("hold_ready_low", 32'(cmd_ready), 32'd0);
      if (k == 2) check("hold_ready_high", 32'(cmd_ready), 32'd1);
      if (k == 3) begin
        check("hold_accepted", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
      end
      if (done) begin
        ndone++;
        if (ndone == 1) first_done = k; else second_done = k;
      end
      if (k == 4) check("hold_mov_data", 32'(wr_data), 32'h3);
      @(negedge clk);
    end
    check("hold_done_count", 32'(ndone), 32'd2);
    check("hold_first_done", 32'(first_done), 32'd1);
    check("hold_second_done", 32'(second_done), 32'd4);
    ref_regs[1] = 3;
    ref_regs[0] = 3;
    check_bank();

    // Reset during RD_B of an ADD that would carry.
    run_cmd(0, 2, 0, 0, 'h9);
    run_cmd(2, 3, 2, 2, 0);
    check("pre_abort_carry", 32'(carry), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_rd = 2'd0; cmd_rs = 2'd2; cmd_rt = 2'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_ready", 32'(cmd_ready), 32'd1);
    check("abort_carry", 32'(carry), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_wr_en", 32'(wr_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    ndone = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done || wr_en != '0) ndone++;
    end
    check("abort_no_write", 32'(ndone), 32'd0);

    // Randomised commands against the architectural model.
    for (int n = 0; n < 60; n++) begin
      run_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
    end
    check_bank();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
